// File: rtl/test_vector_sequencer.sv
// test_vector_sequencer: fetches each vector (plus template/FF config when the template changes) from BRAM_CTRL and hands the bundle to the scan loader
module test_vector_sequencer #(
  parameter int NUM_VECTORS = 256,
  parameter int IDX_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             BRAM_READY,
  input  logic [127:0]     BRAM_RD0,
  input  logic [127:0]     BRAM_RD1,
  input  logic             BRAM_TCHG,
  output logic             INPUT_READ,
  output logic             TEMPLATE_READ,
  output logic             FF_READ,
  output logic [1:0]       TEMPLATE_BITS,
  output logic [127:0]     VEC_DATA,
  output logic [127:0]     TPL_DATA,
  output logic [255:0]     FF_DATA,
  output logic             CFG_UPDATE,
  output logic             VEC_VALID,
  input  logic             VEC_ACCEPT,
  output logic [IDX_W-1:0] VEC_INDEX,
  output logic             BUSY,
  output logic             DONE
);
  typedef enum logic [3:0] {IDLE, IN_REQ, IN_WAIT, TPL_REQ, TPL_WAIT, FF_REQ, FF_WAIT, PRESENT, FIN} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VECTORS - 1);
  state_t state_q, state_d;
  logic wfirst_q, wfirst_d, abort_q, abort_d, first_vec_q, first_vec_d, cfg_q, cfg_d;
  logic [1:0] tbits_q, tbits_d;
  logic [127:0] vec_q, vec_d, tpl_q, tpl_d;
  logic [255:0] ff_q, ff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic abort_now, op_done, reload;
  always_comb begin
    state_d = state_q;
    first_vec_d = first_vec_q;
    cfg_d = cfg_q;
    tbits_d = tbits_q;
    vec_d = vec_q;
    tpl_d = tpl_q;
    ff_d = ff_q;
    idx_d = idx_q;
    wfirst_d = 1'b0;
    INPUT_READ = 1'b0;
    TEMPLATE_READ = 1'b0;
    FF_READ = 1'b0;
    abort_now = ABORT | abort_q;
    op_done = !wfirst_q && BRAM_READY;
    reload = BRAM_TCHG || first_vec_q;
    abort_d = (state_q == IDLE || state_q == FIN) ? 1'b0 : abort_now;
    case (state_q)
      IDLE: if (START && !ABORT) begin
        state_d = IN_REQ;
        idx_d = '0;
        first_vec_d = 1'b1;
      end
      IN_REQ: if (abort_now) state_d = FIN;
        else if (BRAM_READY) begin
          INPUT_READ = 1'b1;
          wfirst_d = 1'b1;
          state_d = IN_WAIT;
        end
      TPL_REQ: if (abort_now) state_d = FIN;
        else if (BRAM_READY) begin
          TEMPLATE_READ = 1'b1;
          wfirst_d = 1'b1;
          state_d = TPL_WAIT;
        end
      FF_REQ: if (abort_now) state_d = FIN;
        else if (BRAM_READY) begin
          FF_READ = 1'b1;
          wfirst_d = 1'b1;
          state_d = FF_WAIT;
        end
      // READY is still high in the first WAIT cycle because BRAM_CTRL drops it one cycle late
      IN_WAIT: if (op_done) begin
        vec_d = BRAM_RD0;
        tbits_d = BRAM_RD0[127:126];
        cfg_d = reload ? cfg_q : 1'b0;
        state_d = abort_now ? FIN : reload ? TPL_REQ : PRESENT;
      end
      TPL_WAIT: if (op_done) begin
        tpl_d = BRAM_RD0;
        state_d = abort_now ? FIN : FF_REQ;
      end
      FF_WAIT: if (op_done) begin
        ff_d = {BRAM_RD1, BRAM_RD0};
        cfg_d = 1'b1;
        first_vec_d = 1'b0;
        state_d = abort_now ? FIN : PRESENT;
      end
      PRESENT: if (abort_now) state_d = FIN;
        else if (VEC_ACCEPT) begin
          if (idx_q == LAST) state_d = FIN;
          else begin
            idx_d = idx_q + 1'b1;
            state_d = IN_REQ;
          end
        end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wfirst_q <= 1'b0;
      abort_q <= 1'b0;
      first_vec_q <= 1'b1;
      cfg_q <= 1'b0;
      tbits_q <= '0;
      vec_q <= '0;
      tpl_q <= '0;
      ff_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      wfirst_q <= wfirst_d;
      abort_q <= abort_d;
      first_vec_q <= first_vec_d;
      cfg_q <= cfg_d;
      tbits_q <= tbits_d;
      vec_q <= vec_d;
      tpl_q <= tpl_d;
      ff_q <= ff_d;
      idx_q <= idx_d;
    end
  end
  assign TEMPLATE_BITS = tbits_q;
  assign VEC_DATA = vec_q;
  assign TPL_DATA = tpl_q;
  assign FF_DATA = ff_q;
  assign CFG_UPDATE = cfg_q;
  assign VEC_INDEX = idx_q;
  assign VEC_VALID = state_q == PRESENT;
  assign DONE = state_q == FIN;
  assign BUSY = !(state_q == IDLE || state_q == FIN);
endmodule

// File: tb/tb_test_vector_sequencer.sv
// tb_test_vector_sequencer: random BRAM_CTRL responder, scoreboarded bundle checks and directed abort/reset/stall runs
module tb_test_vector_sequencer;
  localparam int NV = 4;
  localparam int IW = 2;
  logic CLK = 1'b0, RST = 1'b1, START = 1'b0, ABORT = 1'b0, BRAM_READY = 1'b1, BRAM_TCHG = 1'b0, VEC_ACCEPT = 1'b0;
  logic [127:0] BRAM_RD0 = '0, BRAM_RD1 = '0;
  logic INPUT_READ, TEMPLATE_READ, FF_READ, CFG_UPDATE, VEC_VALID, BUSY, DONE;
  logic [1:0] TEMPLATE_BITS;
  logic [127:0] VEC_DATA, TPL_DATA;
  logic [255:0] FF_DATA;
  logic [IW-1:0] VEC_INDEX;
  test_vector_sequencer #(.NUM_VECTORS(NV), .IDX_W(IW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .BRAM_READY(BRAM_READY),
    .BRAM_RD0(BRAM_RD0), .BRAM_RD1(BRAM_RD1), .BRAM_TCHG(BRAM_TCHG),
    .INPUT_READ(INPUT_READ), .TEMPLATE_READ(TEMPLATE_READ), .FF_READ(FF_READ),
    .TEMPLATE_BITS(TEMPLATE_BITS), .VEC_DATA(VEC_DATA), .TPL_DATA(TPL_DATA), .FF_DATA(FF_DATA),
    .CFG_UPDATE(CFG_UPDATE), .VEC_VALID(VEC_VALID), .VEC_ACCEPT(VEC_ACCEPT),
    .VEC_INDEX(VEC_INDEX), .BUSY(BUSY), .DONE(DONE)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [127:0] v, t;
    logic [255:0] f;
    logic [1:0] tb;
    logic c;
    logic [IW-1:0] i;
  } bundle_t;
  bundle_t exp_q[$];
  bundle_t b;
  int checks = 0, passes = 0;
  logic [127:0] vec_mem[NV];
  logic tchg_mem[NV];
  logic [127:0] tpl_cfg[4];
  logic [255:0] ff_cfg[4];
  bit hold_accept = 0, force_low = 0, no_cmd = 0;
  int discard = 0, tpl_reads = 0, t0 = 0;
  int left = 0, ptr = 0;
  bit pend = 0, cmd = 0, rst_seen = 0, deliver = 0;
  logic [127:0] d0, d1;
  logic tc;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
  endtask
  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  // mode 0 random, 1 all template 01 with change only on vec0, 2 template 00 then 11 on vec1, 3 random with no change flag on vec0
  task automatic plan(input int mode, input int n);
    logic [1:0] cur = 2'b00;
    bundle_t e;
    for (int t = 0; t < 4; t++) begin
      tpl_cfg[t] = r128();
      ff_cfg[t] = {r128(), r128()};
    end
    for (int i = 0; i < NV; i++) begin
      vec_mem[i] = r128();
      tchg_mem[i] = 1'($urandom_range(0, 1));
      if (mode == 1) begin
        vec_mem[i][127:126] = 2'b01;
        tchg_mem[i] = (i == 0);
      end
      if (mode == 2) begin
        tchg_mem[i] = (i == 1);
        if (i < 2) vec_mem[i][127:126] = (i == 0) ? 2'b00 : 2'b11;
      end
      if (mode == 3 && i == 0) tchg_mem[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      e.c = (i == 0) || tchg_mem[i];
      if (e.c) cur = vec_mem[i][127:126];
      e.v = vec_mem[i];
      e.tb = vec_mem[i][127:126];
      e.t = tpl_cfg[cur];
      e.f = ff_cfg[cur];
      e.i = IW'(i);
      exp_q.push_back(e);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask
  task automatic pulse_abort();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
  endtask
  task automatic wait_for(input int sel, input string nm);
    logic hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge CLK);
      hit = sel == 0 ? DONE : sel == 1 ? VEC_VALID : sel == 2 ? INPUT_READ : FF_READ;
    end
    chk(nm, 256'(hit), 256'(1));
  endtask
  task automatic finish_run(input string nm);
    wait_for(0, {nm, "_done"});
    @(negedge CLK);
    chk({nm, "_done_pulse"}, 256'({DONE, BUSY}), 256'(0));
    tick();
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 256'({INPUT_READ, TEMPLATE_READ, FF_READ, TEMPLATE_BITS, CFG_UPDATE, VEC_VALID, VEC_INDEX, BUSY, DONE}), 256'(0));
    chk({nm, "_vec"}, 256'(VEC_DATA), 256'(0));
    chk({nm, "_tpl"}, 256'(TPL_DATA), 256'(0));
    chk({nm, "_ff"}, FF_DATA, 256'(0));
  endtask
  initial begin
    forever begin
      @(negedge CLK);
      cmd = INPUT_READ | TEMPLATE_READ | FF_READ;
      rst_seen = RST;
      if (!RST && START && !BUSY) ptr = 0;
      if (!RST && cmd) begin
        chk("cmd_onehot", 256'($countones({INPUT_READ, TEMPLATE_READ, FF_READ})), 256'(1));
        chk("cmd_legal", 256'({BRAM_READY, pend, no_cmd}), 256'(3'b100));
        if (INPUT_READ) begin
          d0 = vec_mem[ptr % NV];
          tc = tchg_mem[ptr % NV];
          d1 = r128();
          ptr++;
        end else if (TEMPLATE_READ) begin
          d0 = tpl_cfg[TEMPLATE_BITS];
          d1 = r128();
          tc = 1'($urandom_range(0, 1));
          tpl_reads++;
        end else begin
          {d1, d0} = ff_cfg[TEMPLATE_BITS];
          tc = 1'($urandom_range(0, 1));
        end
      end
      @(posedge CLK);
      #2;
      deliver = 0;
      if (rst_seen) begin
        pend = 0;
        BRAM_READY = 1'b1;
      end else if (cmd) begin
        pend = 1;
        left = $urandom_range(1, 4);
        BRAM_READY = 1'b1;
      end else if (pend && left > 0) begin
        left--;
        BRAM_READY = 1'b0;
      end else if (pend) begin
        pend = 0;
        deliver = 1;
        BRAM_READY = 1'b1;
      end else BRAM_READY = !force_low && ($urandom_range(0, 3) != 0);
      BRAM_RD0 = deliver ? d0 : r128();
      BRAM_RD1 = deliver ? d1 : r128();
      BRAM_TCHG = deliver ? tc : 1'($urandom_range(0, 1));
    end
  end
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      VEC_ACCEPT = !hold_accept && ($urandom_range(0, 2) != 0);
    end
  end
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (VEC_VALID) begin
          chk("bundle_expected", 256'(exp_q.size() != 0), 256'(1));
          chk("no_cmd_in_present", 256'({INPUT_READ, TEMPLATE_READ, FF_READ}), 256'(0));
          if (exp_q.size() != 0) begin
            b = exp_q[0];
            chk("vec_data", 256'(VEC_DATA), 256'(b.v));
            chk("template_bits", 256'(TEMPLATE_BITS), 256'(b.tb));
            chk("tpl_data", 256'(TPL_DATA), 256'(b.t));
            chk("ff_data", FF_DATA, b.f);
            chk("cfg_update", 256'(CFG_UPDATE), 256'(b.c));
            chk("vec_index", 256'(VEC_INDEX), 256'(b.i));
            chk("busy_present", 256'(BUSY), 256'(1));
            if (VEC_ACCEPT) void'(exp_q.pop_front());
          end
        end
        if (DONE) begin
          chk("done_leftover", 256'(exp_q.size()), 256'(discard));
          chk("done_not_busy", 256'(BUSY), 256'(0));
          exp_q.delete();
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_zero("reset");
    tick();
    plan(1, NV);
    t0 = tpl_reads;
    pulse_start();
    finish_run("tpl01");
    chk("tpl01_reads", 256'(tpl_reads - t0), 256'(1));
    chk("tpl01_bits_held", 256'(TEMPLATE_BITS), 256'(2'b01));
    plan(2, NV);
    t0 = tpl_reads;
    pulse_start();
    finish_run("tpl00_11");
    chk("tpl00_11_reads", 256'(tpl_reads - t0), 256'(2));
    hold_accept = 1;
    plan(0, NV);
    pulse_start();
    wait_for(1, "hold_valid");
    tick();
    repeat (20) tick();
    hold_accept = 0;
    finish_run("hold");
    force_low = 1;
    plan(0, NV);
    pulse_start();
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      chk("stall_no_input_read", 256'(INPUT_READ), 256'(0));
    end
    tick();
    force_low = 0;
    wait_for(2, "stall_input_read");
    @(negedge CLK);
    chk("stall_single_pulse", 256'(INPUT_READ), 256'(0));
    tick();
    finish_run("stall");
    plan(0, 0);
    pulse_start();
    wait_for(2, "abort_wait_input_read");
    tick();
    no_cmd = 1;
    pulse_abort();
    finish_run("abort_in_wait");
    no_cmd = 0;
    hold_accept = 1;
    discard = 1;
    plan(0, 1);
    pulse_start();
    wait_for(1, "abort_present_valid");
    tick();
    repeat (3) tick();
    pulse_abort();
    finish_run("abort_in_present");
    discard = 0;
    hold_accept = 0;
    force_low = 1;
    plan(0, 0);
    pulse_start();
    tick();
    tick();
    no_cmd = 1;
    pulse_abort();
    finish_run("abort_in_req");
    force_low = 0;
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      chk("start_abort_idle", 256'({BUSY, DONE}), 256'(0));
    end
    tick();
    no_cmd = 0;
    plan(0, NV);
    pulse_start();
    wait_for(3, "rst_wait_ff_read");
    tick();
    tick();
    RST = 1'b1;
    exp_q.delete();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("rst_in_ff_wait");
    for (int n = 0; n < 3; n++) begin
      @(negedge CLK);
      chk("rst_no_done", 256'(DONE), 256'(0));
    end
    tick();
    plan(3, NV);
    pulse_start();
    finish_run("rerun_after_rst");
    for (int r = 0; r < 8; r++) begin
      plan(0, NV);
      pulse_start();
      repeat ($urandom_range(1, 4)) tick();
      pulse_start();
      finish_run("random");
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
